uart_reg_dump: RTL and testbench
================================

UART_REG_DUMP -- requirements
Module: uart_reg_dump

Interface
REQ-001 Parameter CLK_HZ, default 27000000: system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200: serial bit rate; BAUD_DIV = round(CLK_HZ/BAUD), and a BAUD_DIV below 2 SHALL be an elaboration error.
REQ-003 Parameter NUM_REGS, default 8, legal 1..8: number of registers dumped.
REQ-004 Parameter REG_WIDTH, default 16, legal 4..32 and a multiple of 4: bits per register; HEX_DIGITS = REG_WIDTH/4.
REQ-005 Parameter MODE, default 0: 0 dumps on change, 1 dumps periodically.
REQ-006 Parameter PERIOD_CYCLES, default CLK_HZ: periodic dump interval in clocks when MODE=1; it SHALL be at least 1.
REQ-007 clk  input  1  system clock; all logic is on the rising edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 regs  input  array [NUM_REGS-1:0] of REG_WIDTH  register values to dump, element 0 first.
REQ-010 dump_req  input  1  single-cycle request to force a full dump.
REQ-011 uart_tx  output  1  8N1 serial line, idle high.
REQ-012 busy  output  1  high from snapshot until the stop bit of the last byte has finished.
REQ-013 dump_done  output  1  one-cycle pulse when busy falls.

Function
REQ-014 The FSM SHALL have the states IDLE, SNAP, EMIT, DRAIN.
- IDLE -> SNAP when a trigger is pending.
- SNAP (one cycle): copy all regs into snapshot; reg index = 0; char index = 0 -> EMIT.
- EMIT: present the current character to the serializer; on acceptance advance the char index. After the last character of the line, advance the reg index. After the last register -> DRAIN.
- DRAIN: wait for the serializer to be idle, then pulse dump_done -> IDLE.
REQ-015 Each line SHALL be 'R', then ASCII digit of the index, then '=0x', then HEX_DIGITS uppercase hex digits (MSB nibble first), then CR (0x0D), then LF (0x0A); line length = 7 + HEX_DIGITS bytes.
REQ-016 Hex encoding SHALL be: nibble 0-9 -> 0x30+n; nibble 10-15 -> 0x41+n-10.
REQ-017 All characters SHALL come from the snapshot, so changes on regs during a dump do not alter the bytes being sent.
REQ-018 MODE=0 trigger: any regs element differs from its snapshot value while in IDLE.
REQ-019 MODE=1 trigger: period counter reaches PERIOD_CYCLES-1, then wraps to 0. The counter SHALL run continuously, including while busy.
REQ-020 dump_req SHALL trigger a dump in either mode.
REQ-021 A trigger arriving while busy SHALL set a single pending flag; multiple triggers collapse into one. SNAP SHALL be entered on the cycle after DRAIN's dump_done.
REQ-022 A trigger in IDLE SHALL reach SNAP on the next clock; busy SHALL rise on the SNAP cycle.
REQ-023 Serializer handshake is valid/ready; a byte transfers on a cycle where both are high. Ready SHALL be high only while the serializer is idle.
REQ-024 Serial frame: start bit 0, then data bits LSB first, then stop bit 1. Each bit lasts exactly BAUD_DIV clocks. The start bit begins the cycle after acceptance.
REQ-025 Back-to-back bytes SHALL show no idle gap beyond one clock between a stop bit and the next start bit.

Reset
REQ-026 While rst_n is low:
- uart_tx = 1, busy = 0, dump_done = 0
- FSM in IDLE
- snapshot, counters, indices and pending flag cleared to 0
REQ-027 Reset asserted mid-frame SHALL return uart_tx high immediately (asynchronously), with no completion of the frame in progress.
REQ-028 After reset in MODE=0, any nonzero regs element SHALL trigger a dump, because it differs from the zero snapshot.

Structure
REQ-029 Package uart_dump_pkg SHALL hold the FSM state enum, the ASCII constants ('R', '=', '0', 'x', CR, LF), and a function nibble_to_hex.
REQ-030 Sub-module uart_tx_byte SHALL implement the serializer: parameter BAUD_DIV; ports clk, rst_n, data[7:0], valid, ready, tx.
REQ-031 Expected size is roughly 200-300 lines of RTL in total.

Verification
All scenarios use CLK_HZ=1000, BAUD=100 (BAUD_DIV=10), NUM_REGS=2, REG_WIDTH=16 unless stated.
REQ-032 Reset with regs={0,0}, MODE=0, pulse dump_req -> uart_tx decodes "R0=0x0000\r\nR1=0x0000\r\n" (22 bytes, each frame 100 clocks); then a single dump_done pulse and busy low.
REQ-033 MODE=0, regs[1]: 0 -> 16'hBEEF -> line "R1=0xBEEF" appears in the dump; no further dump while regs stay stable.
REQ-034 regs[0] changes to 16'h1234 mid-dump -> the current dump keeps the old value; exactly one follow-up dump shows "R0=0x1234".
REQ-035 MODE=1, PERIOD_CYCLES=5000 -> a dump starts every 5000 clocks; three dump_req pulses during one dump -> only one extra dump.
REQ-036 REG_WIDTH=32, NUM_REGS=1, regs[0]=32'hA5F0_0C3D -> "R0=0xA5F00C3D\r\n"; the start bit of each byte begins one clock after the byte is accepted.
REQ-037 rst_n asserted during the 3rd data bit of a frame -> uart_tx=1 and busy=0 within the same cycle; no dump_done pulse.

Source files
------------

// File: rtl/uart_dump_pkg.sv
// Shared definitions for the UART register dumper.
//   state_e        : dump sequencer states
//   ASCII_*        : fixed characters used to build each "Rn=0x....\r\n" line
//   nibble_to_hex  : 4-bit value to uppercase ASCII hex digit
package uart_dump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SNAP  = 2'd1,
    EMIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  localparam logic [7:0] ASCII_R    = 8'h52;  // 'R'
  localparam logic [7:0] ASCII_EQ   = 8'h3D;  // '='
  localparam logic [7:0] ASCII_ZERO = 8'h30;  // '0'
  localparam logic [7:0] ASCII_X    = 8'h78;  // 'x'
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  // Characters per line that are not hex digits: 'R', index, '=', '0', 'x', CR, LF.
  localparam int LINE_FIXED = 7;

  function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end
    return 8'h37 + {4'h0, n};  // 0x41 + (n - 10)
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer.
//   clk, rst_n : clock, asynchronous active-low reset
//   data       : byte to send, captured when valid && ready
//   valid      : byte offered by the producer
//   ready      : high only while no frame is in flight
//   tx         : serial line, idle high; registered so reset forces it high at once
module uart_tx_byte #(
  parameter int BAUD_DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  logic          active_q, active_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [3:0]    bit_q, bit_d;
  logic [9:0]    frame_q, frame_d;
  logic          tx_q, tx_d;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    tx_d     = tx_q;
    if (!active_q) begin
      if (valid) begin
        // Start bit goes out on the cycle after acceptance.
        active_d = 1'b1;
        frame_d  = {1'b1, data, 1'b0};
        tx_d     = 1'b0;
        baud_d   = '0;
        bit_d    = 4'd0;
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        // Stop bit complete; ready rises next cycle so the next start
        // bit trails the stop bit by a single idle clock.
        active_d = 1'b0;
        tx_d     = 1'b1;
      end else begin
        bit_d   = bit_q + 4'd1;
        frame_d = {1'b1, frame_q[9:1]};
        tx_d    = frame_q[1];
      end
    end else begin
      baud_d = baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      frame_q  <= '1;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      frame_q  <= frame_d;
      tx_q     <= tx_d;
    end
  end

  assign ready = !active_q;
  assign tx    = tx_q;

endmodule

// File: rtl/uart_reg_dump.sv
// Dumps a bank of registers over a UART as text lines "Rn=0xHHHH\r\n".
//   clk       : system clock (rising edge)
//   rst_n     : asynchronous active-low reset
//   regs      : register values, element 0 dumped first
//   dump_req  : single-cycle request for a full dump
//   uart_tx   : 8N1 serial output, idle high
//   busy      : high from the snapshot cycle until the last stop bit ends
//   dump_done : one-cycle pulse on the first cycle busy is low again
// MODE=0 dumps whenever regs differ from the last snapshot; MODE=1 dumps
// every PERIOD_CYCLES clocks. Triggers during a dump collapse into one.
module uart_reg_dump
  import uart_dump_pkg::*;
#(
  parameter int CLK_HZ        = 27000000,
  parameter int BAUD          = 115200,
  parameter int NUM_REGS      = 8,
  parameter int REG_WIDTH     = 16,
  parameter int MODE          = 0,
  parameter int PERIOD_CYCLES = CLK_HZ
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_REGS-1:0][REG_WIDTH-1:0]  regs,
  input  logic                                dump_req,
  output logic                                uart_tx,
  output logic                                busy,
  output logic                                dump_done
);

  localparam int BAUD_DIV   = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int HEX_DIGITS = REG_WIDTH / 4;
  localparam int LINE_LEN   = LINE_FIXED + HEX_DIGITS;
  localparam int RIW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int PW         = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;

  localparam logic [RIW-1:0] REG_LAST    = RIW'(NUM_REGS - 1);
  localparam logic [3:0]     CHAR_LAST   = 4'(LINE_LEN - 1);
  localparam logic [3:0]     HEX_END     = 4'(5 + HEX_DIGITS);  // index of CR
  localparam logic [3:0]     NIB_TOP     = 4'(HEX_DIGITS - 1);
  localparam logic [PW-1:0]  PERIOD_LAST = PW'(PERIOD_CYCLES - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud
    $error("uart_reg_dump: BAUD_DIV must be at least 2");
  end
  if (NUM_REGS < 1 || NUM_REGS > 8) begin : g_bad_num_regs
    $error("uart_reg_dump: NUM_REGS must be 1..8");
  end
  if (REG_WIDTH < 4 || REG_WIDTH > 32 || (REG_WIDTH % 4) != 0) begin : g_bad_width
    $error("uart_reg_dump: REG_WIDTH must be 4..32 and a multiple of 4");
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("uart_reg_dump: MODE must be 0 or 1");
  end
  if (PERIOD_CYCLES < 1) begin : g_bad_period
    $error("uart_reg_dump: PERIOD_CYCLES must be at least 1");
  end

  state_e               state_q, state_d;
  logic [REG_WIDTH-1:0] snap_q [NUM_REGS];
  logic [RIW-1:0]       reg_idx_q, reg_idx_d;
  logic [3:0]           char_idx_q, char_idx_d;
  logic                 pend_q, pend_d;
  logic [PW-1:0]        period_q, period_d;
  logic                 done_q, done_d;

  logic                 changed;
  logic                 period_tick;
  logic                 ext_trig;
  logic                 ser_valid;
  logic                 ser_ready;
  logic [7:0]           cur_char;
  logic [REG_WIDTH-1:0] cur_word;
  logic [3:0]           digit_pos;
  logic [3:0]           nib_idx;
  logic [3:0]           nib;

  // Any live register differing from its snapshot.
  always_comb begin
    changed = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (regs[i] != snap_q[i]) begin
        changed = 1'b1;
      end
    end
  end

  // Free-running interval counter; keeps counting through dumps.
  assign period_tick = (period_q == PERIOD_LAST);
  assign period_d    = period_tick ? '0 : period_q + 1'b1;

  // Triggers that can arrive at any time and are remembered while busy.
  // The change trigger is only meaningful in IDLE: afterwards the live
  // value is compared against the fresh snapshot anyway.
  assign ext_trig = dump_req || ((MODE == 1) && period_tick);

  // Character generator, driven purely from the snapshot.
  assign cur_word  = snap_q[reg_idx_q];
  assign digit_pos = char_idx_q - 4'd5;
  assign nib_idx   = NIB_TOP - digit_pos;
  assign nib       = 4'(cur_word >> {nib_idx, 2'b00});

  always_comb begin
    cur_char = ASCII_LF;
    if (char_idx_q == 4'd0) begin
      cur_char = ASCII_R;
    end else if (char_idx_q == 4'd1) begin
      cur_char = ASCII_ZERO + 8'(reg_idx_q);
    end else if (char_idx_q == 4'd2) begin
      cur_char = ASCII_EQ;
    end else if (char_idx_q == 4'd3) begin
      cur_char = ASCII_ZERO;
    end else if (char_idx_q == 4'd4) begin
      cur_char = ASCII_X;
    end else if (char_idx_q < HEX_END) begin
      cur_char = nibble_to_hex(nib);
    end else if (char_idx_q == HEX_END) begin
      cur_char = ASCII_CR;
    end
  end

  always_comb begin
    state_d    = state_q;
    reg_idx_d  = reg_idx_q;
    char_idx_d = char_idx_q;
    pend_d     = pend_q;
    done_d     = 1'b0;
    ser_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ext_trig || pend_q || ((MODE == 0) && changed)) begin
          state_d = SNAP;
        end
      end
      SNAP: begin
        pend_d     = 1'b0;
        reg_idx_d  = '0;
        char_idx_d = 4'd0;
        state_d    = EMIT;
      end
      EMIT: begin
        ser_valid = 1'b1;
        if (ser_ready) begin
          if (char_idx_q == CHAR_LAST) begin
            char_idx_d = 4'd0;
            if (reg_idx_q == REG_LAST) begin
              state_d = DRAIN;
            end else begin
              reg_idx_d = reg_idx_q + 1'b1;
            end
          end else begin
            char_idx_d = char_idx_q + 4'd1;
          end
        end
      end
      DRAIN: begin
        if (ser_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A trigger seen while busy (SNAP cycle included) is held for one more dump.
    if (state_q != IDLE && ext_trig) begin
      pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      reg_idx_q  <= '0;
      char_idx_q <= 4'd0;
      pend_q     <= 1'b0;
      period_q   <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      reg_idx_q  <= reg_idx_d;
      char_idx_q <= char_idx_d;
      pend_q     <= pend_d;
      period_q   <= period_d;
      done_q     <= done_d;
      if (state_q == SNAP) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          snap_q[i] <= regs[i];
        end
      end
    end
  end

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .data (cur_char),
    .valid(ser_valid),
    .ready(ser_ready),
    .tx   (uart_tx)
  );

  assign busy      = (state_q != IDLE);
  assign dump_done = done_q;

endmodule

// File: tb/tb_uart_reg_dump.sv
module tb_uart_reg_dump;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // dut0: MODE 0, 2 x 16 bit
  logic             rst_n0, req0, tx0, busy0, done0;
  logic [1:0][15:0] regs0;
  // dut1: MODE 1, period 5000, 2 x 16 bit
  logic             rst_n1, req1, tx1, busy1, done1;
  logic [1:0][15:0] regs1;
  // dut2: MODE 0, 1 x 32 bit
  logic             rst_n2, req2, tx2, busy2, done2;
  logic [0:0][31:0] regs2;

  uart_reg_dump #(.CLK_HZ(1000), .BAUD(100), .NUM_REGS(2), .REG_WIDTH(16),
                  .MODE(0), .PERIOD_CYCLES(1000)) dut0 (
    .clk(clk), .rst_n(rst_n0), .regs(regs0), .dump_req(req0),
    .uart_tx(tx0), .busy(busy0), .dump_done(done0));

  uart_reg_dump #(.CLK_HZ(1000), .BAUD(100), .NUM_REGS(2), .REG_WIDTH(16),
                  .MODE(1), .PERIOD_CYCLES(5000)) dut1 (
    .clk(clk), .rst_n(rst_n1), .regs(regs1), .dump_req(req1),
    .uart_tx(tx1), .busy(busy1), .dump_done(done1));

  uart_reg_dump #(.CLK_HZ(1000), .BAUD(100), .NUM_REGS(1), .REG_WIDTH(32),
                  .MODE(0), .PERIOD_CYCLES(1000)) dut2 (
    .clk(clk), .rst_n(rst_n2), .regs(regs2), .dump_req(req2),
    .uart_tx(tx2), .busy(busy2), .dump_done(done2));

  int   rx_sel = 0;
  logic rx_line;
  logic busy_sel;
  always_comb begin
    case (rx_sel)
      0:       begin rx_line = tx0; busy_sel = busy0; end
      1:       begin rx_line = tx1; busy_sel = busy1; end
      default: begin rx_line = tx2; busy_sel = busy2; end
    endcase
  end

  // Event monitors (sampled on the falling edge).
  int   done_cnt0 = 0;
  logic busy1_prev = 1'b0;
  logic busy2_prev = 1'b0;
  int   rise1_q[$];
  int   done1_q[$];
  int   rise2_q[$];
  always @(negedge clk) begin
    if (done0 === 1'b1) done_cnt0 <= done_cnt0 + 1;
    if (busy1 === 1'b1 && busy1_prev === 1'b0) rise1_q.push_back(cyc);
    if (done1 === 1'b1) done1_q.push_back(cyc);
    if (busy2 === 1'b1 && busy2_prev === 1'b0) rise2_q.push_back(cyc);
    busy1_prev <= busy1;
    busy2_prev <= busy2;
  end

  int st[32];  // start-bit cycle of each received byte

  function automatic string show(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0D)      r = {r, "\\r"};
      else if (s[i] == 8'h0A) r = {r, "\\n"};
      else                    r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  // UART receiver: samples mid-bit on the selected line; bad framing gives '?'.
  task automatic recv_str(input int n, output string s);
    logic [7:0] b;
    bit ok;
    int waitn;
    s = "";
    for (int k = 0; k < n; k++) begin
      ok = 1'b1;
      waitn = 0;
      b = 8'h00;
      while (rx_line !== 1'b0 && waitn < 12000) begin
        @(negedge clk);
        waitn++;
      end
      if (waitn >= 12000) begin
        s = {s, "?"};
        return;
      end
      st[k] = cyc;
      repeat (4) @(negedge clk);
      if (rx_line !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (10) @(negedge clk);
        b[i] = rx_line;
      end
      repeat (10) @(negedge clk);
      if (rx_line !== 1'b1) ok = 1'b0;
      if (!ok) b = 8'h3F;
      s = $sformatf("%s%c", s, b);
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy_sel !== 1'b0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    ok = (busy_sel === 1'b0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n0 = 1'b0; req0 = 1'b0; regs0 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx0 !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx0); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy0); end
    checks++;
    if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done0); end
    rst_n0 = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy0 !== 1'b0 || done_cnt0 !== 0)
      begin errors++; $display("FAIL idle_zero_regs busy=%b dones=%0d exp busy=0 dones=0", busy0, done_cnt0); end
    $display("test_reset done");
  endtask

  task automatic test_dump_req;
    string s;
    bit ok;
    int d = done_cnt0;
    rx_sel = 0;
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_rise got=%b exp=1", busy0); end
    recv_str(22, s);
    checks++;
    if (s != "R0=0x0000\r\nR1=0x0000\r\n")
      begin errors++; $display("FAIL req_dump_text got=%s exp=R0=0x0000\\r\\nR1=0x0000\\r\\n", show(s)); end
    wait_idle(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL req_busy_fall got=%b exp=0", busy0); end
    checks++;
    if (done_cnt0 - d !== 1) begin errors++; $display("FAIL req_done_pulses got=%0d exp=1", done_cnt0 - d); end
    $display("test_dump_req text=%s", show(s));
  endtask

  task automatic test_change;
    string s;
    bit ok;
    int d = done_cnt0;
    rx_sel = 0;
    regs0[1] = 16'hBEEF;
    recv_str(22, s);
    checks++;
    if (s != "R0=0x0000\r\nR1=0xBEEF\r\n")
      begin errors++; $display("FAIL change_text got=%s exp=R0=0x0000\\r\\nR1=0xBEEF\\r\\n", show(s)); end
    wait_idle(ok);
    repeat (300) @(negedge clk);
    checks++;
    if (!ok || busy0 !== 1'b0) begin errors++; $display("FAIL change_quiet busy=%b exp=0", busy0); end
    checks++;
    if (done_cnt0 - d !== 1) begin errors++; $display("FAIL change_dumps got=%0d exp=1", done_cnt0 - d); end
    $display("test_change text=%s", show(s));
  endtask

  task automatic test_mid_dump_change;
    string s1, s2;
    bit ok;
    int d = done_cnt0;
    rx_sel = 0;
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    fork
      recv_str(22, s1);
      begin
        repeat (300) @(negedge clk);
        regs0[0] = 16'h1234;
      end
    join
    checks++;
    if (s1 != "R0=0x0000\r\nR1=0xBEEF\r\n")
      begin errors++; $display("FAIL mid_old_text got=%s exp=R0=0x0000\\r\\nR1=0xBEEF\\r\\n", show(s1)); end
    recv_str(22, s2);
    checks++;
    if (s2 != "R0=0x1234\r\nR1=0xBEEF\r\n")
      begin errors++; $display("FAIL mid_new_text got=%s exp=R0=0x1234\\r\\nR1=0xBEEF\\r\\n", show(s2)); end
    wait_idle(ok);
    repeat (300) @(negedge clk);
    checks++;
    if (!ok || busy0 !== 1'b0) begin errors++; $display("FAIL mid_quiet busy=%b exp=0", busy0); end
    checks++;
    if (done_cnt0 - d !== 2) begin errors++; $display("FAIL mid_dumps got=%0d exp=2", done_cnt0 - d); end
    $display("test_mid_dump_change first=%s second=%s", show(s1), show(s2));
  endtask

  task automatic test_reset_midframe;
    string s;
    bit ok;
    int n = 0;
    int d = done_cnt0;
    rx_sel = 0;
    req0 = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    while (tx0 !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx0 !== 1'b0) begin errors++; $display("FAIL midrst_start got=%b exp=0", tx0); end
    repeat (35) @(negedge clk);  // inside data bit 2 of 'R' (a zero bit)
    checks++;
    if (tx0 !== 1'b0) begin errors++; $display("FAIL midrst_bit2 got=%b exp=0", tx0); end
    #2 rst_n0 = 1'b0;
    #1;
    checks++;
    if (tx0 !== 1'b1) begin errors++; $display("FAIL midrst_tx got=%b exp=1", tx0); end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy0); end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt0 !== d || tx0 !== 1'b1)
      begin errors++; $display("FAIL midrst_no_done dones=%0d tx=%b exp dones=%0d tx=1", done_cnt0 - d, tx0, 0); end
    rst_n0 = 1'b1;  // nonzero regs differ from the cleared snapshot
    recv_str(22, s);
    checks++;
    if (s != "R0=0x1234\r\nR1=0xBEEF\r\n")
      begin errors++; $display("FAIL post_reset_text got=%s exp=R0=0x1234\\r\\nR1=0xBEEF\\r\\n", show(s)); end
    wait_idle(ok);
    checks++;
    if (!ok || done_cnt0 - d !== 1)
      begin errors++; $display("FAIL post_reset_done got=%0d exp=1", done_cnt0 - d); end
    $display("test_reset_midframe text=%s", show(s));
  endtask

  task automatic test_wide;
    string s;
    rx_sel = 2;
    rst_n2 = 1'b1;
    recv_str(15, s);
    checks++;
    if (s != "R0=0xA5F00C3D\r\n")
      begin errors++; $display("FAIL wide_text got=%s exp=R0=0xA5F00C3D\\r\\n", show(s)); end
    checks++;
    if (rise2_q.size() != 1 || st[0] - rise2_q[0] !== 2)
      begin errors++; $display("FAIL wide_first_start rises=%0d delta=%0d exp rises=1 delta=2",
                               rise2_q.size(), (rise2_q.size() > 0) ? st[0] - rise2_q[0] : -1); end
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (st[k+1] - st[k] !== 101)
        begin errors++; $display("FAIL wide_gap%0d got=%0d exp=101", k, st[k+1] - st[k]); end
    end
    $display("test_wide text=%s", show(s));
  endtask

  task automatic test_periodic;
    string s;
    int r;
    int t1;
    int t3;
    int n = 0;
    rx_sel = 1;
    rise1_q.delete();
    done1_q.delete();
    rst_n1 = 1'b1;
    r = cyc;
    while (busy1 !== 1'b1 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc;
    checks++;
    if (t1 - r !== 5000) begin errors++; $display("FAIL period_first got=%0d exp=5000", t1 - r); end
    recv_str(22, s);
    checks++;
    if (s != "R0=0x7F3C\r\nR1=0x00A0\r\n")
      begin errors++; $display("FAIL period_text got=%s exp=R0=0x7F3C\\r\\nR1=0x00A0\\r\\n", show(s)); end
    n = 0;
    while (rise1_q.size() < 2 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (rise1_q.size() < 2 || rise1_q[1] - rise1_q[0] !== 5000)
      begin errors++; $display("FAIL period_interval rises=%0d exp 2 rises 5000 apart", rise1_q.size()); end
    t3 = (rise1_q.size() >= 2) ? rise1_q[1] : cyc;
    for (int p = 0; p < 3; p++) begin
      repeat (100) @(negedge clk);
      req1 = 1'b1;
      @(negedge clk);
      req1 = 1'b0;
    end
    while (cyc < t3 + 5010) @(negedge clk);
    checks++;
    if (rise1_q.size() !== 4) begin errors++; $display("FAIL collapse_rises got=%0d exp=4", rise1_q.size()); end
    checks++;
    if (done1_q.size() !== 3) begin errors++; $display("FAIL collapse_dones got=%0d exp=3", done1_q.size()); end
    checks++;
    if (rise1_q.size() < 3 || done1_q.size() < 2 || rise1_q[2] !== done1_q[1] + 1)
      begin errors++; $display("FAIL pending_snap rises=%0d dones=%0d exp snap one cycle after done",
                               rise1_q.size(), done1_q.size()); end
    checks++;
    if (rise1_q.size() < 4 || rise1_q[3] !== t3 + 5000)
      begin errors++; $display("FAIL period_after_extra rises=%0d exp rise at +5000", rise1_q.size()); end
    $display("test_periodic text=%s rises=%0d dones=%0d", show(s), rise1_q.size(), done1_q.size());
  endtask

  initial begin
    rst_n0 = 1'b0; req0 = 1'b0; regs0 = '0;
    rst_n1 = 1'b0; req1 = 1'b0; regs1[0] = 16'h7F3C; regs1[1] = 16'h00A0;
    rst_n2 = 1'b0; req2 = 1'b0; regs2[0] = 32'hA5F0_0C3D;
    @(negedge clk);
    test_reset();
    test_dump_req();
    test_change();
    test_mid_dump_change();
    test_reset_midframe();
    test_wide();
    test_periodic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
